// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: FSM states and framing constants shared by the RMII receive path
package eth_rx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;
  localparam int MII_WIDTH = 2;
  localparam logic [MII_WIDTH-1:0] PRE_DIBIT = 2'b01;
  localparam logic [MII_WIDTH-1:0] SFD_DIBIT = 2'b11;
  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int DST_LEN = 6;
  localparam int HDR_LEN = 14;
  localparam int FCS_LEN = 4;
  localparam int MIN_FRAME = 18;
endpackage

// File: rtl/eth_crc_gen.sv
// eth_crc_gen: byte-wide Ethernet CRC-32; Crc_Req re-arms, Byte_Rdy folds in Byte, Crc_Out holds FCS wire bytes b0..b3 as {b0,b1,b2,b3}
module eth_crc_gen (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Crc_Req,
  input  logic        Byte_Rdy,
  input  logic [7:0]  Byte,
  output logic [31:0] Crc_Out
);
  localparam logic [31:0] POLY = 32'hEDB8_8320;
  logic [31:0] crc, crc_nx;
  always_comb begin
    crc_nx = crc;
    for (int i = 0; i < 8; i++) crc_nx = (crc_nx >> 1) ^ ((crc_nx[0] ^ Byte[i]) ? POLY : 32'h0);
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) crc <= '1;
    else if (Crc_Req) crc <= '1;
    else if (Byte_Rdy) crc <= crc_nx;
  assign Crc_Out = {~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24]};
endmodule

// File: rtl/eth_rx_dibit_asm.sv
// eth_rx_dibit_asm: LSB-dibit-first byte assembler; Byte_Done strobes while Byte holds a complete byte, Partial flags a mid-byte position
module eth_rx_dibit_asm
  import eth_rx_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Clr,
  input  logic                 En,
  input  logic [MII_WIDTH-1:0] Rxd,
  output logic [7:0]           Byte,
  output logic                 Byte_Done,
  output logic                 Partial
);
  logic [1:0] cnt;
  assign Partial = cnt != 2'd0;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      Byte <= '0;
      cnt <= '0;
      Byte_Done <= 1'b0;
    end else begin
      Byte_Done <= En && &cnt;
      if (Clr) cnt <= '0;
      else if (En) begin
        Byte <= {Rxd, Byte[7:MII_WIDTH]};
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/eth_rx.sv
// eth_rx: RMII receiver (Clk/Rst_n, Rxd/Crs_Dv in) -> address-filtered payload stream (Eth_Byte*), Eth_Len_Type, and frame verdict (Eth_Pkt_*)
module eth_rx
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] pMAC_ADDR = 48'h020000000001,
  parameter logic        pPROMISC = 1'b0,
  parameter int          pMIN_PRE_DIBITS = 8,
  parameter int          pMAX_FRAME_BYTES = 1518
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [MII_WIDTH-1:0] Rxd,
  input  logic                 Crs_Dv,
  output logic [7:0]           Eth_Byte,
  output logic                 Eth_Byte_Valid,
  output logic [15:0]          Eth_Len_Type,
  output logic                 Eth_Pkt_Done,
  output logic                 Eth_Pkt_Ok,
  output logic [2:0]           Eth_Pkt_Err
);
  localparam int CW = $clog2(pMAX_FRAME_BYTES + 2);
  localparam int PW = $clog2(pMIN_PRE_DIBITS + 1);
  localparam logic [PW-1:0] PRE_MIN = PW'(pMIN_PRE_DIBITS);
  localparam logic [CW-1:0] MAX_CNT = CW'(pMAX_FRAME_BYTES + 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_FRAME);
  localparam logic [CW-1:0] FCS_CNT = CW'(FCS_LEN);
  localparam logic [CW-1:0] DST_END = CW'(DST_LEN - 1);
  localparam logic [CW-1:0] LEN_HI = CW'(HDR_LEN - 2);
  localparam logic [CW-1:0] HDR_END = CW'(HDR_LEN - 1);
  state_t state, state_nx;
  logic [PW-1:0] pre_cnt;
  logic [CW-1:0] byte_cnt;
  logic [3:0][7:0] dly;
  logic [39:0] dst;
  logic [7:0] rx_byte;
  logic [31:0] crc_out;
  logic [2:0] err_nx;
  logic armed, ovf, done_req, in_frame, sfd, take, emit, byte_done, partial, dst_ok, too_long, short_f;
  assign in_frame = state == HEADER || state == PAYLOAD;
  assign sfd = state == PREAMBLE && Crs_Dv && Rxd == SFD_DIBIT && pre_cnt >= PRE_MIN;
  assign take = in_frame && byte_done;
  assign emit = take && byte_cnt >= MIN_CNT;
  assign dst_ok = pPROMISC || {dst, rx_byte} == pMAC_ADDR || {dst, rx_byte} == BCAST_ADDR;
  assign too_long = byte_cnt + 1'b1 == MAX_CNT;
  assign short_f = ovf || byte_cnt < MIN_CNT;
  assign err_nx = {partial, short_f, !short_f && dly != crc_out};
  eth_rx_dibit_asm u_asm (
    .Clk, .Rst_n, .Clr(sfd), .En(in_frame && Crs_Dv), .Rxd,
    .Byte(rx_byte), .Byte_Done(byte_done), .Partial(partial)
  );
  eth_crc_gen u_crc (
    .Clk, .Rst_n, .Crc_Req(sfd), .Byte_Rdy(take && byte_cnt >= FCS_CNT),
    .Byte(dly[3]), .Crc_Out(crc_out)
  );
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= state_nx;
  // armed stays low until carrier has been seen idle, so a reset released mid-frame is treated as false carrier
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !Crs_Dv ? IDLE : (armed && Rxd == PRE_DIBIT) ? PREAMBLE : DROP;
      PREAMBLE: state_nx = !Crs_Dv ? IDLE : sfd ? HEADER : Rxd == PRE_DIBIT ? PREAMBLE : DROP;
      HEADER, PAYLOAD: state_nx = !Crs_Dv ? IDLE : !take ? state : too_long ? DROP :
                                  (byte_cnt == DST_END && !dst_ok) ? DROP : byte_cnt == HDR_END ? PAYLOAD : state;
      default: state_nx = Crs_Dv ? DROP : IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      pre_cnt <= '0;
      byte_cnt <= '0;
      dly <= '0;
      dst <= '0;
      armed <= 1'b0;
      ovf <= 1'b0;
      done_req <= 1'b0;
      Eth_Byte <= '0;
      Eth_Byte_Valid <= 1'b0;
      Eth_Len_Type <= '0;
      Eth_Pkt_Done <= 1'b0;
      Eth_Pkt_Ok <= 1'b0;
      Eth_Pkt_Err <= '0;
    end else begin
      armed <= armed | ~Crs_Dv;
      pre_cnt <= state == IDLE ? PW'(1) : pre_cnt + PW'(pre_cnt != PRE_MIN);
      byte_cnt <= sfd ? '0 : byte_cnt + CW'(take);
      ovf <= (ovf && !done_req && !sfd) || (take && too_long);
      done_req <= (in_frame || (state == DROP && ovf)) && !Crs_Dv;
      Eth_Pkt_Done <= done_req;
      Eth_Pkt_Ok <= done_req && err_nx == 3'b000;
      Eth_Pkt_Err <= done_req ? err_nx : 3'b000;
      Eth_Byte_Valid <= emit;
      if (emit) Eth_Byte <= dly[3];
      if (take) begin
        dly <= {dly[2:0], rx_byte};
        dst <= {dst[31:0], rx_byte};
      end
      if (take && byte_cnt == LEN_HI) Eth_Len_Type[15:8] <= rx_byte;
      if (take && byte_cnt == HDR_END) Eth_Len_Type[7:0] <= rx_byte;
    end
endmodule
